// File: rtl/falcon_img_pkg.sv
// Shared image-pipeline definitions: frame geometry defaults, RAM bus widths,
// gap-filler state encoding and scan direction.
package falcon_img_pkg;

  localparam int IMG_WIDTH_DEF    = 320;
  localparam int IMG_HEIGHT_DEF   = 240;
  localparam int MARGIN_LINES_DEF = 7;
  localparam int ADDR_W           = 18;
  localparam int DATA_W           = 32;
  localparam int MAX_GAP          = 4;
  localparam int FILL_VALUE       = 1;

  typedef enum logic [2:0] {
    IDLE,
    RC,
    RA,
    RB,
    EV,
    WR,
    DONE
  } filler_state_t;

  typedef enum logic {
    DIR_X,
    DIR_Y
  } dir_t;

  // Distance 0 behaves as 1; anything above MAX_GAP is clamped to MAX_GAP.
  function automatic logic [2:0] clamp_gap(input logic [2:0] gap);
    if (gap == 3'd0) return 3'd1;
    if (gap > 3'(MAX_GAP)) return 3'(MAX_GAP);
    return gap;
  endfunction

endpackage

// File: rtl/pixel_gap_filler_if.sv
// Single-port frame RAM bus: registered address/write side from the master,
// read data returned one cycle after the address.
interface pixel_gap_filler_if
  import falcon_img_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DW = DATA_W
);
  logic [AW-1:0] address;
  logic [DW-1:0] data_write;
  logic          wren;
  logic [DW-1:0] data_read;

  modport master (output address, output data_write, output wren, input data_read);
  modport slave  (input address, input data_write, input wren, output data_read);
endinterface

// File: rtl/pixel_scan_addr_gen.sv
// Raster scan position for the gap filler: x/y counters over the non-margin
// rows, centre/neighbour/destination addresses and neighbour-in-image flags.
module pixel_scan_addr_gen
  import falcon_img_pkg::*;
#(
  parameter int IMG_WIDTH    = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT   = IMG_HEIGHT_DEF,
  parameter int MARGIN_LINES = MARGIN_LINES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_init,
  input  logic              i_step,
  input  dir_t              i_dir,
  input  logic [2:0]        i_dist,
  input  logic [ADDR_W-1:0] i_src_base,
  input  logic [ADDR_W-1:0] i_dst_base,
  output logic [ADDR_W-1:0] o_addr_c,
  output logic [ADDR_W-1:0] o_addr_a,
  output logic [ADDR_W-1:0] o_addr_b,
  output logic [ADDR_W-1:0] o_addr_dst,
  output logic              o_a_valid,
  output logic              o_b_valid,
  output logic              o_last
);

  localparam int XW = $clog2(IMG_WIDTH + 1);
  localparam int YW = $clog2(IMG_HEIGHT + 1);

  logic [XW-1:0]     r_x;
  logic [YW-1:0]     r_y;
  logic [ADDR_W-1:0] w_c;
  logic [ADDR_W-1:0] w_off;
  logic              w_x_end;

  assign w_x_end = (r_x == XW'(IMG_WIDTH - 1));

  // Scan position: x runs fastest, y starts below the top margin.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_init) begin
      r_x <= '0;
      r_y <= YW'(MARGIN_LINES);
    end else if (i_step) begin
      if (w_x_end) begin
        r_x <= '0;
        r_y <= r_y + YW'(1);
      end else begin
        r_x <= r_x + XW'(1);
      end
    end
  end

  // Addresses (modulo 2^ADDR_W) and neighbour-in-image flags; no row wrap.
  always_comb begin
    // NOTE: every output gets a value on every path, so no latch is inferred.
    w_c   = ADDR_W'(r_y) * ADDR_W'(IMG_WIDTH) + ADDR_W'(r_x);
    w_off = (i_dir == DIR_Y) ? ADDR_W'(i_dist) * ADDR_W'(IMG_WIDTH) : ADDR_W'(i_dist);
    o_addr_c   = i_src_base + w_c;
    o_addr_a   = i_src_base + w_c - w_off;
    o_addr_b   = i_src_base + w_c + w_off;
    o_addr_dst = i_dst_base + w_c;
    if (i_dir == DIR_Y) begin
      o_a_valid = (32'(r_y) >= 32'(i_dist));
      o_b_valid = (32'(r_y) + 32'(i_dist) < 32'(IMG_HEIGHT));
    end else begin
      o_a_valid = (32'(r_x) >= 32'(i_dist));
      o_b_valid = (32'(r_x) + 32'(i_dist) < 32'(IMG_WIDTH));
    end
    o_last = w_x_end && (r_y == YW'(IMG_HEIGHT - MARGIN_LINES - 1));
  end

endmodule

// File: rtl/pixel_gap_filler.sv
// Fills single-pixel edge gaps: a pixel becomes FILL_VALUE when both neighbours
// at distance d (along X or Y) are FILL_VALUE. Five RAM cycles per pixel;
// writes in place or to a separate destination buffer and counts fills.
module pixel_gap_filler
  import falcon_img_pkg::*;
#(
  parameter int IMG_WIDTH    = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT   = IMG_HEIGHT_DEF,
  parameter int MARGIN_LINES = MARGIN_LINES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pause,
  input  logic              enable,
  input  logic              mode_y,
  input  logic [2:0]        gap_dist,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  output logic [17:0]       fill_count,
  output logic              done,
  pixel_gap_filler_if.master ram
);

  localparam bit                EMPTY_SCAN = (IMG_HEIGHT <= 2 * MARGIN_LINES);
  localparam logic [DATA_W-1:0] FILL_WORD  = DATA_W'(FILL_VALUE);

  filler_state_t     r_state;
  dir_t              r_dir;
  logic [2:0]        r_dist;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [DATA_W-1:0] r_center;
  logic [DATA_W-1:0] r_nb_a;
  logic [ADDR_W-1:0] r_address;
  logic [DATA_W-1:0] r_data_write;
  logic              r_wren;
  logic              r_done;
  logic [17:0]       r_fill_count;

  logic              w_active;
  logic              w_init;
  logic              w_step;
  logic [ADDR_W-1:0] w_addr_c;
  logic [ADDR_W-1:0] w_addr_a;
  logic [ADDR_W-1:0] w_addr_b;
  logic [ADDR_W-1:0] w_addr_dst;
  logic              w_a_valid;
  logic              w_b_valid;
  logic              w_last;
  logic              w_fill;
  logic [DATA_W-1:0] w_result;

  assign w_active = !reset && !pause && enable;
  assign w_init   = w_active && (r_state == IDLE);
  assign w_step   = w_active && (r_state == WR);

  pixel_scan_addr_gen #(
    .IMG_WIDTH   (IMG_WIDTH),
    .IMG_HEIGHT  (IMG_HEIGHT),
    .MARGIN_LINES(MARGIN_LINES)
  ) u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .i_init    (w_init),
    .i_step    (w_step),
    .i_dir     (r_dir),
    .i_dist    (r_dist),
    .i_src_base(r_src),
    .i_dst_base(r_dst),
    .o_addr_c  (w_addr_c),
    .o_addr_a  (w_addr_a),
    .o_addr_b  (w_addr_b),
    .o_addr_dst(w_addr_dst),
    .o_a_valid (w_a_valid),
    .o_b_valid (w_b_valid),
    .o_last    (w_last)
  );

  // Fill decision in WR, where data_read carries neighbour B.
  always_comb begin
    w_fill = w_a_valid && (r_nb_a == FILL_WORD) &&
             w_b_valid && (ram.data_read == FILL_WORD) &&
             (r_center != FILL_WORD);
    w_result = w_fill ? FILL_WORD : r_center;
  end

  // Control FSM, RAM port registers, data capture and fill counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_address    <= '0;
      r_data_write <= '0;
      r_wren       <= 1'b0;
      r_done       <= 1'b0;
      r_fill_count <= '0;
      // NOTE: config and pixel capture registers are left unreset; they are
      // always written before being used.
    end else if (!pause) begin
      if (!enable) begin
        r_state      <= IDLE;
        r_address    <= '0;
        r_data_write <= '0;
        r_wren       <= 1'b0;
        r_done       <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_dir        <= mode_y ? DIR_Y : DIR_X;
            r_dist       <= clamp_gap(gap_dist);
            r_src        <= src_base;
            r_dst        <= dst_base;
            r_fill_count <= '0;
            r_state      <= EMPTY_SCAN ? DONE : RC;
            r_done       <= EMPTY_SCAN;
          end
          RC: begin
            r_address <= w_addr_c;
            r_wren    <= 1'b0;
            r_state   <= RA;
          end
          RA: begin
            r_address <= w_addr_a;
            r_state   <= RB;
          end
          RB: begin
            r_address <= w_addr_b;
            r_center  <= ram.data_read;
            r_state   <= EV;
          end
          EV: begin
            r_nb_a  <= ram.data_read;
            r_state <= WR;
          end
          WR: begin
            r_address    <= w_addr_dst;
            r_wren       <= 1'b1;
            r_data_write <= w_result;
            if (w_fill && (r_fill_count != '1)) r_fill_count <= r_fill_count + 18'd1;
            r_state <= w_last ? DONE : RC;
            r_done  <= w_last;
          end
          DONE: begin
            r_done    <= 1'b1;
            r_wren    <= 1'b0;
            r_address <= '0;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign ram.address    = r_address;
  assign ram.data_write = r_data_write;
  assign ram.wren       = r_wren;
  assign fill_count     = r_fill_count;
  assign done           = r_done;

endmodule

// File: tb/tb_pixel_gap_filler.sv
// Self-checking bench for pixel_gap_filler on an 8x6 frame with one margin row.
// A behavioural RAM serves the DUT; a loop-based reference model predicts the
// whole memory image and fill count after each pass.
module tb_pixel_gap_filler;
  import falcon_img_pkg::*;

  localparam int W = 8;
  localparam int H = 6;
  localparam int M = 1;
  localparam int MEMSZ = 1024;

  logic        clk = 1'b0;
  logic        reset, pause, enable, mode_y;
  logic [2:0]  gap_dist;
  logic [17:0] src_base, dst_base;
  logic [17:0] fill_count;
  logic        done;

  pixel_gap_filler_if #(.AW(18), .DW(32)) ram ();

  pixel_gap_filler #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .MARGIN_LINES(M)) dut (
    .clk(clk), .reset(reset), .pause(pause), .enable(enable), .mode_y(mode_y),
    .gap_dist(gap_dist), .src_base(src_base), .dst_base(dst_base),
    .fill_count(fill_count), .done(done), .ram(ram)
  );

  always #5 clk = ~clk;

  // RAM with a backdoor write port used only while the DUT is idle.
  logic [31:0] mem [0:MEMSZ-1];
  logic [31:0] ref_mem [0:MEMSZ-1];
  logic        bd_we = 1'b0;
  logic [9:0]  bd_addr = '0;
  logic [31:0] bd_data = '0;
  int          wr_log[$];

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (ram.wren === 1'b1) mem[ram.address[9:0]] <= ram.data_write;
    ram.data_read <= mem[ram.address[9:0]];
  end

  always @(posedge clk) if (ram.wren === 1'b1 && !bd_we) wr_log.push_back(int'(ram.address));

  int n_total = 0;
  int n_pass  = 0;

  task automatic mem_write(input int a, input logic [31:0] d);
    bd_we = 1'b1; bd_addr = 10'(a); bd_data = d;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  task automatic load_image(input int base, input int pct);
    for (int i = 0; i < W * H; i++) mem_write(base + i, ($urandom_range(0, 99) < pct) ? 32'd1 : 32'd0);
  endtask

  // Reference: scan the frame in raster order, reading the current memory so
  // in-place updates feed later pixels exactly as the hardware sees them.
  task automatic model_pass(input bit my, input int d, input int sb, input int db, output int cnt);
    ref_mem = mem;
    cnt = 0;
    for (int y = M; y < H - M; y++) begin
      for (int x = 0; x < W; x++) begin
        int  c;
        bit  a_ok, b_ok, fill;
        c = y * W + x;
        if (my) begin
          a_ok = (y - d >= 0) && (ref_mem[sb + c - d * W] == 32'd1);
          b_ok = (y + d < H)  && (ref_mem[sb + c + d * W] == 32'd1);
        end else begin
          a_ok = (x - d >= 0) && (ref_mem[sb + c - d] == 32'd1);
          b_ok = (x + d < W)  && (ref_mem[sb + c + d] == 32'd1);
        end
        fill = a_ok && b_ok && (ref_mem[sb + c] != 32'd1);
        ref_mem[db + c] = fill ? 32'd1 : ref_mem[sb + c];
        if (fill) cnt++;
      end
    end
  endtask

  function automatic int count_diffs();
    int n = 0;
    for (int i = 0; i < MEMSZ; i++) if (mem[i] !== ref_mem[i]) n++;
    return n;
  endfunction

  // Starts a pass and waits (bounded) for done; optionally pauses 3 cycles
  // while the pause_wr-th write is on the bus and records whether it froze.
  task automatic run_pass(input bit my, input logic [2:0] gd, input int sb, input int db,
                          input int pause_wr, output int cycles, output bit tmo, output bit frz);
    int          wr_n;
    logic [17:0] a0;
    logic [31:0] d0;
    mode_y = my; gap_dist = gd; src_base = 18'(sb); dst_base = 18'(db);
    wr_log.delete();
    frz = 1'b1; wr_n = 0;
    enable = 1'b1;
    @(posedge clk); #1;
    cycles = 0;
    while (done !== 1'b1 && cycles < 2000) begin
      if (ram.wren === 1'b1) begin
        if (wr_n == pause_wr) begin
          a0 = ram.address; d0 = ram.data_write; pause = 1'b1;
          repeat (3) begin
            @(posedge clk); #1; cycles++;
            if (ram.address !== a0 || ram.data_write !== d0 || ram.wren !== 1'b1) frz = 1'b0;
          end
          pause = 1'b0;
        end
        wr_n++;
      end
      @(posedge clk); #1; cycles++;
    end
    tmo = (done !== 1'b1);
  endtask

  // Lets the final write land, then drops enable back to idle.
  task automatic finish_pass();
    repeat (2) begin @(posedge clk); #1; end
    enable = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; pause = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    n_total++; if (ram.address !== 18'd0) $display("FAIL reset_address: got %0d expected 0", ram.address); else n_pass++;
    n_total++; if (ram.data_write !== 32'd0) $display("FAIL reset_data_write: got %0d expected 0", ram.data_write); else n_pass++;
    n_total++; if (ram.wren !== 1'b0) $display("FAIL reset_wren: got %0b expected 0", ram.wren); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %0b expected 0", done); else n_pass++;
    n_total++; if (fill_count !== 18'd0) $display("FAIL reset_fill_count: got %0d expected 0", fill_count); else n_pass++;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_y_fill();
    int cyc, cnt; bit tmo, frz;
    for (int i = 0; i < W * H; i++) mem_write(i, 32'd0);
    mem_write(3, 32'd1); mem_write(19, 32'd1);
    model_pass(1'b1, 1, 0, 0, cnt);
    run_pass(1'b1, 3'd1, 0, 0, -1, cyc, tmo, frz);
    n_total++; if (tmo) $display("FAIL y_timeout: done not seen after %0d cycles", cyc); else n_pass++;
    n_total++; if (cyc !== 160) $display("FAIL y_latency: got %0d expected 160", cyc); else n_pass++;
    repeat (3) begin @(posedge clk); #1; end
    n_total++; if (done !== 1'b1 || ram.wren !== 1'b0 || ram.address !== 18'd0)
      $display("FAIL y_done_hold: done=%0b wren=%0b addr=%0d expected 1 0 0", done, ram.wren, ram.address); else n_pass++;
    n_total++; if (mem[11] !== 32'd1) $display("FAIL y_word11: got %0d expected 1", mem[11]); else n_pass++;
    n_total++; if (fill_count !== 18'd1) $display("FAIL y_fill_count: got %0d expected 1", fill_count); else n_pass++;
    n_total++; if (count_diffs() !== 0) $display("FAIL y_memory: %0d words differ expected 0", count_diffs()); else n_pass++;
    n_total++; if (wr_log.size() !== 32) $display("FAIL y_write_count: got %0d expected 32", wr_log.size()); else n_pass++;
    enable = 1'b0;
    @(posedge clk); #1;
    n_total++; if (done !== 1'b0 || fill_count !== 18'(cnt))
      $display("FAIL y_done_clear: done=%0b fill=%0d expected 0 %0d", done, fill_count, cnt); else n_pass++;
  endtask

  task automatic test_x_gap();
    int cyc, cnt, bad; bit tmo, frz;
    for (int i = 0; i < W * H; i++) mem_write(i, 32'd0);
    mem_write(17, 32'd1); mem_write(18, 32'd1); mem_write(21, 32'd1);
    model_pass(1'b0, 2, 0, 0, cnt);
    run_pass(1'b0, 3'd2, 0, 0, -1, cyc, tmo, frz);
    finish_pass();
    bad = 0;
    foreach (wr_log[i]) if (wr_log[i] < 8 || wr_log[i] >= 40) bad++;
    n_total++; if (tmo) $display("FAIL x_timeout: done not seen after %0d cycles", cyc); else n_pass++;
    n_total++; if (mem[19] !== 32'd1) $display("FAIL x_word19: got %0d expected 1", mem[19]); else n_pass++;
    n_total++; if (mem[16] !== 32'd0) $display("FAIL x_word16_edge: got %0d expected 0", mem[16]); else n_pass++;
    n_total++; if (fill_count !== 18'd1) $display("FAIL x_fill_count: got %0d expected 1", fill_count); else n_pass++;
    n_total++; if (bad !== 0) $display("FAIL x_margin_writes: got %0d expected 0", bad); else n_pass++;
    n_total++; if (count_diffs() !== 0) $display("FAIL x_memory: %0d words differ expected 0", count_diffs()); else n_pass++;
  endtask

  task automatic test_dst_buffer();
    int cyc, cnt, bad, changed; bit tmo, frz, my;
    logic [31:0] snap [0:W*H-1];
    load_image(0, 45);
    for (int i = 100; i < 148; i++) mem_write(i, 32'd7);
    for (int i = 0; i < W * H; i++) snap[i] = mem[i];
    my = 1'($urandom_range(0, 1));
    model_pass(my, 1, 0, 100, cnt);
    run_pass(my, 3'd1, 0, 100, -1, cyc, tmo, frz);
    finish_pass();
    bad = 0; changed = 0;
    foreach (wr_log[i]) if (wr_log[i] < 108 || wr_log[i] > 139) bad++;
    for (int i = 0; i < W * H; i++) if (mem[i] !== snap[i]) changed++;
    n_total++; if (tmo) $display("FAIL dst_timeout: done not seen after %0d cycles", cyc); else n_pass++;
    n_total++; if (changed !== 0) $display("FAIL dst_src_untouched: got %0d changed expected 0", changed); else n_pass++;
    n_total++; if (bad !== 0) $display("FAIL dst_write_range: got %0d out of range expected 0", bad); else n_pass++;
    n_total++; if (count_diffs() !== 0) $display("FAIL dst_memory: %0d words differ expected 0", count_diffs()); else n_pass++;
    n_total++; if (fill_count !== 18'(cnt)) $display("FAIL dst_fill_count: got %0d expected %0d", fill_count, cnt); else n_pass++;
  endtask

  task automatic test_pause();
    int cyc, cnt; bit tmo, frz, my;
    load_image(0, 50);
    my = 1'($urandom_range(0, 1));
    model_pass(my, 1, 0, 0, cnt);
    run_pass(my, 3'd1, 0, 0, 5, cyc, tmo, frz);
    finish_pass();
    n_total++; if (tmo) $display("FAIL pause_timeout: done not seen after %0d cycles", cyc); else n_pass++;
    n_total++; if (frz !== 1'b1) $display("FAIL pause_freeze: got %0b expected 1", frz); else n_pass++;
    n_total++; if (cyc !== 163) $display("FAIL pause_latency: got %0d expected 163", cyc); else n_pass++;
    n_total++; if (count_diffs() !== 0) $display("FAIL pause_memory: %0d words differ expected 0", count_diffs()); else n_pass++;
    n_total++; if (fill_count !== 18'(cnt)) $display("FAIL pause_fill_count: got %0d expected %0d", fill_count, cnt); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int cyc, cnt; bit tmo, frz;
    load_image(0, 50);
    mode_y = 1'b0; gap_dist = 3'd1; src_base = '0; dst_base = '0; enable = 1'b1;
    repeat (18) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    n_total++; if (ram.address !== 18'd0 || ram.data_write !== 32'd0 || ram.wren !== 1'b0)
      $display("FAIL rst_mid_bus: addr=%0d data=%0d wren=%0b expected 0 0 0", ram.address, ram.data_write, ram.wren); else n_pass++;
    n_total++; if (done !== 1'b0 || fill_count !== 18'd0)
      $display("FAIL rst_mid_status: done=%0b fill=%0d expected 0 0", done, fill_count); else n_pass++;
    reset = 1'b0; enable = 1'b0;
    @(posedge clk); #1;
    enable = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    n_total++; if (ram.address !== 18'd8) $display("FAIL rst_mid_restart: got %0d expected 8", ram.address); else n_pass++;
    enable = 1'b0;
    @(posedge clk); #1;
    model_pass(1'b0, 1, 0, 0, cnt);
    run_pass(1'b0, 3'd1, 0, 0, -1, cyc, tmo, frz);
    finish_pass();
    n_total++; if (tmo || count_diffs() !== 0) $display("FAIL rst_mid_rerun: tmo=%0b diffs=%0d expected 0 0", tmo, count_diffs()); else n_pass++;
  endtask

  task automatic test_abort_ev();
    mode_y = 1'b1; gap_dist = 3'd1; src_base = '0; dst_base = '0; enable = 1'b1;
    repeat (14) begin @(posedge clk); #1; end
    enable = 1'b0;
    @(posedge clk); #1;
    n_total++; if (ram.wren !== 1'b0 || ram.address !== 18'd0 || done !== 1'b0)
      $display("FAIL abort_outputs: wren=%0b addr=%0d done=%0b expected 0 0 0", ram.wren, ram.address, done); else n_pass++;
    enable = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    n_total++; if (ram.address !== 18'd8) $display("FAIL abort_restart: got %0d expected 8", ram.address); else n_pass++;
    enable = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_gap_clamp();
    int cyc, cnt; bit tmo, frz, my;
    logic [2:0] gds [2] = '{3'd0, 3'd7};
    int         mds [2] = '{1, 4};
    for (int k = 0; k < 2; k++) begin
      load_image(0, 60);
      my = 1'($urandom_range(0, 1));
      model_pass(my, mds[k], 0, 0, cnt);
      run_pass(my, gds[k], 0, 0, -1, cyc, tmo, frz);
      finish_pass();
      n_total++; if (tmo || count_diffs() !== 0)
        $display("FAIL clamp_gap%0d_memory: tmo=%0b diffs=%0d expected 0 0", gds[k], tmo, count_diffs()); else n_pass++;
      n_total++; if (fill_count !== 18'(cnt))
        $display("FAIL clamp_gap%0d_count: got %0d expected %0d", gds[k], fill_count, cnt); else n_pass++;
    end
  endtask

  task automatic test_random();
    int cyc, cnt, d, sb, db; bit tmo, frz, my;
    for (int k = 0; k < 4; k++) begin
      my = 1'($urandom_range(0, 1));
      d  = $urandom_range(1, 4);
      sb = ($urandom_range(0, 1) == 1) ? 200 : 0;
      db = ($urandom_range(0, 1) == 1) ? sb : sb + 300;
      load_image(sb, $urandom_range(30, 70));
      model_pass(my, d, sb, db, cnt);
      run_pass(my, 3'(d), sb, db, -1, cyc, tmo, frz);
      finish_pass();
      n_total++; if (tmo || count_diffs() !== 0)
        $display("FAIL rand%0d_memory: tmo=%0b diffs=%0d expected 0 0", k, tmo, count_diffs()); else n_pass++;
      n_total++; if (fill_count !== 18'(cnt))
        $display("FAIL rand%0d_count: got %0d expected %0d", k, fill_count, cnt); else n_pass++;
    end
  endtask

  initial begin
    reset = 1'b1; pause = 1'b0; enable = 1'b0; mode_y = 1'b0;
    gap_dist = 3'd1; src_base = '0; dst_base = '0;
    for (int i = 0; i < MEMSZ; i++) mem_write(i, 32'd0);
    test_reset();
    test_y_fill();
    test_x_gap();
    test_dst_buffer();
    test_pause();
    test_reset_mid();
    test_abort_ev();
    test_gap_clamp();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
